processing_swap_control: RTL
============================

PROCESSING_SWAP_CONTROL -- requirements
Module: processing_swap_control

Interface
REQ-001 SHALL have parameter N_ITR, default 180: projection-angle iterations per frame, >=1.
REQ-002 SHALL have parameter SH_W, default 16: width of sw_sh_accu_base.
REQ-003 SHALL have parameter MP_W, default 16: width of sw_mp_accu_init and sw_mp_accu_base.
REQ-004 SHALL have parameters SH_STEP, MP_INIT_STEP and MP_BASE_STEP, default 1 each: per-iteration increments.
REQ-005 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: kick  input  1  one-cycle frame start pulse.
REQ-008 SHALL have port: buf_free  input  1  downstream buffer bank free; gates the swap.
REQ-009 SHALL have port: sw_next_itr  input  1  state control is ready for the next iteration.
REQ-010 SHALL have port: sw_swap  input  1  state control fill done, requests swap.
REQ-011 SHALL have port: sw_next_itr_ack  output  1  registered one-cycle grant of the next iteration.
REQ-012 SHALL have port: sw_swap_ack  output  1  registered one-cycle grant of the swap.
REQ-013 SHALL have port: sw_sh_accu_base  output  SH_W  shifter accumulator base, registered.
REQ-014 SHALL have port: sw_mp_accu_init  output  MP_W  mapper accumulator initial value, registered.
REQ-015 SHALL have port: sw_mp_accu_base  output  MP_W  mapper accumulator base, registered.
REQ-016 SHALL have port: bank_sel  output  1  active buffer bank, registered.
REQ-017 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port: done  output  1  registered one-cycle frame completion pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, WAIT_ITR, WAIT_SWAP and WAIT_LAST.
REQ-020 In IDLE, kick=1 SHALL clear itr_cnt, all three accumulator outputs and bank_sel to 0, then go to WAIT_ITR; kick SHALL be ignored in all other states.
REQ-021 In WAIT_ITR, sw_next_itr=1 SHALL set sw_next_itr_ack=1 for exactly the next cycle and move to WAIT_SWAP on the same edge.
REQ-022 In WAIT_SWAP, sw_swap=1 with buf_free=1 SHALL set sw_swap_ack=1 for exactly the next cycle, toggle bank_sel and increment itr_cnt on the same edge.
REQ-023 On that same edge, each accumulator SHALL advance by its step, wrapping modulo 2^width.
REQ-024 In WAIT_SWAP, sw_swap=1 with buf_free=0 SHALL stall with no ack and no state change until buf_free=1.
REQ-025 After a swap grant, the FSM SHALL go to WAIT_LAST if the incremented itr_cnt equals N_ITR, else to WAIT_ITR.
REQ-026 In WAIT_LAST, sw_next_itr=1 (last shift finished) SHALL pulse done for one cycle, go to IDLE and issue no ack.
REQ-027 The accumulator outputs SHALL change only on a swap-grant edge or a kick, so they are stable whenever sw_next_itr is high.
REQ-028 Requests not matching the current state SHALL be ignored, including sw_swap while in WAIT_ITR.
REQ-029 sw_next_itr_ack and sw_swap_ack SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-030 itr_cnt SHALL be ceil(log2(N_ITR+1)) bits wide and SHALL never exceed N_ITR.

Reset
REQ-031 Asserting reset at any time, including mid-frame, SHALL immediately force IDLE and drive every output (acks, accumulators, bank_sel, busy, done) to 0.
REQ-032 After reset deasserts, the block SHALL act only on a new kick.

Verification
REQ-033 SHALL test a full frame: N_ITR=3, SH_STEP=5, MP_INIT_STEP=2, MP_BASE_STEP=7, buf_free=1, kick then handshakes. Required response: sw_sh_accu_base 0,5,10 at each sw_next_itr_ack; bank_sel 0->1->0->1; one done pulse after the 4th sw_next_itr; busy then falls.
REQ-034 SHALL test backpressure: buf_free=0 for 10 cycles while sw_swap=1. Required response: no sw_swap_ack and bank_sel unchanged; the ack appears the cycle after buf_free rises.
REQ-035 SHALL test wrap-around: SH_W=4, SH_STEP=6, N_ITR=4. Required response: sw_sh_accu_base sequence 0,6,12,2.
REQ-036 SHALL test reset mid-frame: reset asserted while in WAIT_SWAP with itr_cnt=2. Required response: all outputs 0 at once; after release, no ack occurs until kick.
REQ-037 SHALL test spurious inputs: kick while busy, and sw_swap while in WAIT_ITR. Required response: both ignored; accumulators and itr_cnt unchanged.
REQ-038 SHALL test the single-iteration frame: N_ITR=1. Required response: one next_itr ack, one swap ack, then done on the next sw_next_itr.

Source files
------------

// File: rtl/processing_swap_control.sv
// ---------------------------------------------------------------------------
// processing_swap_control
//
// Frame-level sequencer for the double-buffered projection pipeline. A frame
// is N_ITR iterations. Each iteration grants the state control permission
// to start the next iteration, then waits for the fill-done swap request.
// On a granted swap the active buffer bank flips, the iteration counter
// advances and the three accumulator bases step forward. After the last
// swap, one more sw_next_itr closes the frame with a done pulse.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   kick             in   one-cycle frame start pulse (accepted in IDLE only)
//   buf_free         in   downstream bank free; a swap is held off while low
//   sw_next_itr      in   state control ready for the next iteration
//   sw_swap          in   state control fill done, requests swap
//   sw_next_itr_ack  out  one-cycle grant of the next iteration
//   sw_swap_ack      out  one-cycle grant of the swap
//   sw_sh_accu_base  out  shifter accumulator base      [SH_W]
//   sw_mp_accu_init  out  mapper accumulator init value [MP_W]
//   sw_mp_accu_base  out  mapper accumulator base       [MP_W]
//   bank_sel         out  active buffer bank
//   busy             out  high whenever the FSM is not in IDLE
//   done             out  one-cycle frame completion pulse
// All outputs are registered.
// ---------------------------------------------------------------------------
module processing_swap_control #(
    parameter int N_ITR        = 180,
    parameter int SH_W         = 16,
    parameter int MP_W         = 16,
    parameter int SH_STEP      = 1,
    parameter int MP_INIT_STEP = 1,
    parameter int MP_BASE_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            kick,
    input  logic            buf_free,
    input  logic            sw_next_itr,
    input  logic            sw_swap,
    output logic            sw_next_itr_ack,
    output logic            sw_swap_ack,
    output logic [SH_W-1:0] sw_sh_accu_base,
    output logic [MP_W-1:0] sw_mp_accu_init,
    output logic [MP_W-1:0] sw_mp_accu_base,
    output logic            bank_sel,
    output logic            busy,
    output logic            done
);

    // Counter holds 0..N_ITR inclusive.
    localparam int CNT_W = (N_ITR < 1) ? 1 : $clog2(N_ITR + 1);

    // Steps truncated to the accumulator width so additions wrap modulo 2^width.
    localparam logic [SH_W-1:0]  SH_INC      = SH_W'(SH_STEP);
    localparam logic [MP_W-1:0]  MP_INIT_INC = MP_W'(MP_INIT_STEP);
    localparam logic [MP_W-1:0]  MP_BASE_INC = MP_W'(MP_BASE_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(N_ITR);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ITR  = 2'd1,
        WAIT_SWAP = 2'd2,
        WAIT_LAST = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] itr_cnt_r;
    logic [CNT_W-1:0] itr_cnt_inc_s;
    logic             last_itr_s;
    logic             swap_grant_s;

    // Next-count and end-of-frame decode used on the swap-grant edge.
    always_comb begin
        itr_cnt_inc_s = itr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (itr_cnt_inc_s == CNT_LAST) begin
            last_itr_s = 1'b1;
        end else begin
            last_itr_s = 1'b0;
        end
    end

    // A swap is granted only when requested and the downstream bank is free.
    always_comb begin
        if ((state_r == WAIT_SWAP) && sw_swap && buf_free) begin
            swap_grant_s = 1'b1;
        end else begin
            swap_grant_s = 1'b0;
        end
    end

    // Frame FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            itr_cnt_r       <= '0;
            sw_next_itr_ack <= 1'b0;
            sw_swap_ack     <= 1'b0;
            sw_sh_accu_base <= '0;
            sw_mp_accu_init <= '0;
            sw_mp_accu_base <= '0;
            bank_sel        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            sw_next_itr_ack <= 1'b0;
            sw_swap_ack     <= 1'b0;
            done            <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (kick) begin
                        itr_cnt_r       <= '0;
                        sw_sh_accu_base <= '0;
                        sw_mp_accu_init <= '0;
                        sw_mp_accu_base <= '0;
                        bank_sel        <= 1'b0;
                        busy            <= 1'b1;
                        state_r         <= WAIT_ITR;
                    end
                end
                WAIT_ITR: begin
                    if (sw_next_itr) begin
                        sw_next_itr_ack <= 1'b1;
                        state_r         <= WAIT_SWAP;
                    end
                end
                WAIT_SWAP: begin
                    // Without buf_free the request simply stalls here.
                    if (swap_grant_s) begin
                        sw_swap_ack     <= 1'b1;
                        bank_sel        <= ~bank_sel;
                        itr_cnt_r       <= itr_cnt_inc_s;
                        sw_sh_accu_base <= sw_sh_accu_base + SH_INC;
                        sw_mp_accu_init <= sw_mp_accu_init + MP_INIT_INC;
                        sw_mp_accu_base <= sw_mp_accu_base + MP_BASE_INC;
                        state_r         <= last_itr_s ? WAIT_LAST : WAIT_ITR;
                    end
                end
                WAIT_LAST: begin
                    // Final sw_next_itr marks the last shift finished: no ack.
                    if (sw_next_itr) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
